branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage dynamic branch predictor with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters. It sits upstream of the EX-stage branch decision logic. In IF it predicts taken/target for the current PC. In EX it consumes the resolved outcome (the branch decision bit `r`) and the computed target, updates its tables, and raises a misprediction redirect to the PC mux and the flush logic.

## Interface
Parameters:
- `INDEX_BITS`, 6 — BTB index width; the table has 2^INDEX_BITS entries, indexed by PC[INDEX_BITS+1:2].
- `XLEN`, 32 — PC and target width; the tag is PC[XLEN-1:INDEX_BITS+2].

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — synchronous, active-low reset.
- `if_pc` in XLEN — PC of the instruction being fetched.
- `pred_taken` out 1 — combinational prediction for `if_pc`.
- `pred_target` out XLEN — predicted target; `if_pc+4` when not predicted taken.
- `ex_valid` in 1 — a conditional branch or JALR is resolving in EX this cycle; high for one cycle per instruction.
- `ex_pc` in XLEN — PC of the resolving instruction.
- `ex_pred_taken` in 1 — prediction carried down the pipeline for that instruction.
- `ex_pred_target` in XLEN — predicted target carried down the pipeline.
- `ex_taken` in 1 — resolved outcome (the branch decision bit).
- `ex_target` in XLEN — computed target (branch offset or JALR).
- `mispredict` out 1 — combinational; a flush/redirect is required.
- `redirect_pc` out XLEN — correct next PC: `ex_target` if `ex_taken`, else `ex_pc+4`.
- `stat_branches` out 32 — resolved-branch count (see Configuration).
- `stat_mispredicts` out 32 — misprediction count (see Configuration).

## Operation
Each entry holds `valid`, `tag`, `target`, and `ctr[1:0]`.

Lookup (IF, combinational):
- Hit = entry `valid` and tag equals the `if_pc` tag.
- `pred_taken` = hit & `ctr[1]`.
- `pred_target` = entry `target` if `pred_taken`, else `if_pc+4`.

Update (EX, on the clock edge when `ex_valid`=1 and `rst`=1):
- Hit on `ex_pc`, taken: `ctr` increments and saturates at 2'b11; `target` <= `ex_target`.
- Hit on `ex_pc`, not taken: `ctr` decrements and saturates at 2'b00; `target` is unchanged.
- Miss, taken: allocate the entry (overwrite). Set `valid`=1, write the tag and `target`=`ex_target`, and set `ctr`=2'b10.
- Miss, not taken: no change.

Misprediction:
- `mispredict` = `ex_valid` & ((`ex_taken` != `ex_pred_taken`) | (`ex_taken` & `ex_pred_taken` & `ex_target` != `ex_pred_target`)).
- `redirect_pc` is valid whenever `mispredict`=1; its value is don't-care otherwise.

Arithmetic:
- PC+4 wraps modulo 2^XLEN.
- PC bits [1:0] are ignored for indexing and tagging.

## Timing
- Lookup latency is 0 cycles (purely combinational on `if_pc`).
- `mispredict` and `redirect_pc` have 0-cycle latency from the EX inputs.
- Table updates become visible to lookup the cycle after the `ex_valid` edge. A same-cycle read of the entry being written returns the old contents; there is no bypass.

Reset (`rst`=0 sampled on an edge):
- All `valid` bits clear and all `ctr` become 2'b01; `target` and `tag` are don't-care.
- Statistic counters become 0.
- While `rst`=0: `pred_taken`=0, `pred_target`=`if_pc+4`, and `mispredict`=0. `ex_valid` is ignored; no update and no count.

Boundary conditions:
- Reset asserted mid-stream discards the update for that cycle.
- An aliasing branch with a different tag replaces the entry only when taken.
- A counter at 2'b11 with taken, or at 2'b00 with not taken, stays put.
- `ex_pc` equal to `if_pc` in the same cycle: the prediction uses the pre-update state.

## Configuration
- `BP_STATS_EN` defined:
  - `stat_branches` increments on every accepted `ex_valid`.
  - `stat_mispredicts` increments when `mispredict`=1.
  - Both are 32-bit and wrap to 0 after 0xFFFFFFFF.
- `BP_STATS_EN` not defined:
  - Counter registers are not synthesised; both ports are tied to 0.
  - Prediction and update behaviour is identical.

## Test plan
- Reset, then `if_pc`=0x100 → `pred_taken`=0, `pred_target`=0x104, `stat_branches`=0.
- Cold taken branch:
  - Stimulus: `ex_valid`, `ex_pc`=0x100, `ex_pred_taken`=0, `ex_taken`=1, `ex_target`=0x80.
  - Same cycle: `mispredict`=1, `redirect_pc`=0x80.
  - Next cycle, `if_pc`=0x100: `pred_taken`=1, `pred_target`=0x80.
- Saturation, starting from the allocated entry above:
  - Two not-taken updates on 0x100 → prediction becomes not taken (`ctr` 2'b10→2'b01→2'b00).
  - A third not-taken update leaves `ctr` at 2'b00.
  - One taken update → still not predicted.
- Alias: entry for 0x100 valid and taken; a taken update at 0x100+4·2^INDEX_BITS (0x200 at the default) replaces it → lookup at 0x100 misses, predicting 0x104.
- Target change: predicted taken to 0x80, resolved taken to 0x90 → `mispredict`=1, `redirect_pc`=0x90, and the entry target becomes 0x90.
- Reset mid-operation: `rst`=0 with `ex_valid`=1 → `mispredict`=0, the table is cleared, and the stats stay 0. With `BP_STATS_EN`, after 3 branches and 1 mispredict the stats read 3 and 1.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle for the branch predictor.
// master = pipeline (drives PCs and resolved outcomes), slave = predictor.
interface branch_predictor_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;

    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;

    modport master (
        output if_pc,
        output ex_valid,
        output ex_pc,
        output ex_pred_taken,
        output ex_pred_target,
        output ex_taken,
        output ex_target,
        input  pred_taken,
        input  pred_target,
        input  mispredict,
        input  redirect_pc,
        input  stat_branches,
        input  stat_mispredicts
    );

    modport slave (
        input  if_pc,
        input  ex_valid,
        input  ex_pc,
        input  ex_pred_taken,
        input  ex_pred_target,
        input  ex_taken,
        input  ex_target,
        output pred_taken,
        output pred_target,
        output mispredict,
        output redirect_pc,
        output stat_branches,
        output stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters.
// Branch/mispredict statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned XLEN       = 32
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);
    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = XLEN - INDEX_BITS - 2;

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0]   tag_t;
    typedef logic [XLEN-1:0]       addr_t;

    logic       valid_q  [ENTRIES];
    tag_t       tag_q    [ENTRIES];
    addr_t      target_q [ENTRIES];
    logic [1:0] ctr_q    [ENTRIES];

    idx_t if_idx;
    tag_t if_tag;
    idx_t ex_idx;
    tag_t ex_tag;

    assign if_idx = bp.if_pc[INDEX_BITS+1:2];
    assign if_tag = bp.if_pc[XLEN-1:INDEX_BITS+2];
    assign ex_idx = bp.ex_pc[INDEX_BITS+1:2];
    assign ex_tag = bp.ex_pc[XLEN-1:INDEX_BITS+2];

    // Instruction-alignment bits play no part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

    // Lookup
    logic if_hit;
    logic if_taken;

    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_taken       = rst && if_hit && ctr_q[if_idx][1];
    assign bp.pred_taken  = if_taken;
    assign bp.pred_target = if_taken ? target_q[if_idx] : bp.if_pc + addr_t'(4);

    // Misprediction and redirect
    logic dir_wrong;
    logic tgt_wrong;
    logic mispredict;

    assign dir_wrong      = bp.ex_taken != bp.ex_pred_taken;
    assign tgt_wrong      = bp.ex_taken && bp.ex_pred_taken &&
                            (bp.ex_target != bp.ex_pred_target);
    assign mispredict     = rst && bp.ex_valid && (dir_wrong || tgt_wrong);
    assign bp.mispredict  = mispredict;
    assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + addr_t'(4);

    // Update
    logic       upd_en;
    logic       ex_hit;
    logic [1:0] ctr_cur;
    logic [1:0] ctr_d;
    logic       ctr_we;
    logic       entry_we;

    assign upd_en  = rst && bp.ex_valid;
    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ctr_cur = ctr_q[ex_idx];

    always_comb begin
        ctr_d    = ctr_cur;
        ctr_we   = 1'b0;
        entry_we = 1'b0;
        if (upd_en) begin
            if (ex_hit) begin
                ctr_we = 1'b1;
                if (bp.ex_taken) begin
                    entry_we = 1'b1;
                    if (ctr_cur != 2'b11) begin
                        ctr_d = ctr_cur + 2'd1;
                    end
                end else if (ctr_cur != 2'b00) begin
                    ctr_d = ctr_cur - 2'd1;
                end
            end else if (bp.ex_taken) begin
                // Taken miss allocates over whatever alias held the slot.
                ctr_we   = 1'b1;
                entry_we = 1'b1;
                ctr_d    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '{default: 1'b0};
            ctr_q   <= '{default: 2'b01};
        end else begin
            if (ctr_we) begin
                ctr_q[ex_idx] <= ctr_d;
            end
            if (entry_we) begin
                valid_q[ex_idx] <= 1'b1;
            end
        end
    end

    // Tag and target need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (entry_we) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= bp.ex_target;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mp_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            br_cnt_q <= 32'd0;
            mp_cnt_q <= 32'd0;
        end else begin
            if (upd_en) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (mispredict) begin
                mp_cnt_q <= mp_cnt_q + 32'd1;
            end
        end
    end

    assign bp.stat_branches    = br_cnt_q;
    assign bp.stat_mispredicts = mp_cnt_q;
`else
    assign bp.stat_branches    = 32'd0;
    assign bp.stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against an entry-level behavioural model of the BTB.
module tb_branch_predictor;
    localparam int IB = 6;
    localparam int N  = 1 << IB;
    localparam int XL = 32;
`ifdef BP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(XL)) bp ();
    branch_predictor #(.INDEX_BITS(IB), .XLEN(XL)) dut (.clk(clk), .rst(rst), .bp(bp));

    int total = 0;
    int bad   = 0;

    // Model: one record per slot, counter kept as a plain integer 0..3.
    bit          m_valid [N];
    int          m_ctr   [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    logic [31:0] m_br;
    logic [31:0] m_mp;

    function automatic int m_idx(logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic logic [31:0] m_tagof(logic [31:0] pc);
        return pc >> (IB + 2);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_pred_taken(logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(logic [31:0] pc);
        return m_pred_taken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_misp(bit pt, logic [31:0] ptgt, bit t, logic [31:0] tgt);
        return (t != pt) || (t && pt && (tgt != ptgt));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic m_update(logic [31:0] pc, bit t, logic [31:0] tgt);
        int k;
        k = m_idx(pc);
        if (m_hit(pc)) begin
            if (t) begin
                m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
                m_tgt[k] = tgt;
            end else begin
                m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
            end
        end else if (t) begin
            m_valid[k] = 1'b1;
            m_tag[k]   = m_tagof(pc);
            m_tgt[k]   = tgt;
            m_ctr[k]   = 2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(logic [31:0] pc, bit pt, logic [31:0] ptgt, bit t,
                            logic [31:0] tgt);
        bp.ex_valid       = 1'b1;
        bp.ex_pc          = pc;
        bp.ex_pred_taken  = pt;
        bp.ex_pred_target = ptgt;
        bp.ex_taken       = t;
        bp.ex_target      = tgt;
        #1;
    endtask

    // Applies the driven EX transaction to the model, then clocks it into the DUT.
    task automatic commit_ex();
        if (rst && bp.ex_valid) begin
            m_br = m_br + 1;
            if (m_misp(bp.ex_pred_taken, bp.ex_pred_target, bp.ex_taken, bp.ex_target))
                m_mp = m_mp + 1;
            m_update(bp.ex_pc, bp.ex_taken, bp.ex_target);
        end
        tick();
        bp.ex_valid = 1'b0;
    endtask

    // Short predicted-direction update on pc using the model's own prediction.
    task automatic resolve(logic [31:0] pc, bit t, logic [31:0] tgt);
        drive_ex(pc, m_pred_taken(pc), m_pred_target(pc), t, tgt);
        commit_ex();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bp.if_pc = 32'h100;
        drive_ex(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        tick();
        tick();
        total++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h104) begin
            bad++;
            $display("FAIL reset_pred: got %0b/%h want 0/00000104", bp.pred_taken,
                     bp.pred_target);
        end
        total++;
        if (bp.mispredict !== 1'b0) begin
            bad++;
            $display("FAIL reset_mispredict: got %0b want 0", bp.mispredict);
        end
        bp.ex_valid = 1'b0;
        rst = 1'b1;
        m_reset();
        #1;
        total++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h104 ||
            bp.stat_branches !== 32'd0 || bp.stat_mispredicts !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: got %0b/%h/%0d/%0d want 0/00000104/0/0",
                     bp.pred_taken, bp.pred_target, bp.stat_branches, bp.stat_mispredicts);
        end
    endtask

    task automatic test_cold_taken();
        bp.if_pc = 32'h100;
        drive_ex(32'h100, 1'b0, 32'h104, 1'b1, 32'h80);
        total++;
        if (bp.mispredict !== 1'b1 || bp.redirect_pc !== 32'h80) begin
            bad++;
            $display("FAIL cold_mispredict: got %0b/%h want 1/00000080", bp.mispredict,
                     bp.redirect_pc);
        end
        // Same-cycle lookup of the entry being written sees the old (empty) state.
        total++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h104) begin
            bad++;
            $display("FAIL cold_same_cycle: got %0b/%h want 0/00000104", bp.pred_taken,
                     bp.pred_target);
        end
        commit_ex();
        total++;
        if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h80) begin
            bad++;
            $display("FAIL cold_alloc: got %0b/%h want 1/00000080", bp.pred_taken,
                     bp.pred_target);
        end
    endtask

    task automatic test_saturation();
        bit exp_t [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bit dir   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bp.if_pc = 32'h100;
        for (int i = 0; i < 5; i++) begin
            resolve(32'h100, dir[i], 32'h80);
            total++;
            if (bp.pred_taken !== exp_t[i] || bp.pred_taken !== m_pred_taken(32'h100)) begin
                bad++;
                $display("FAIL saturation_step%0d: got %0b want %0b", i, bp.pred_taken,
                         exp_t[i]);
            end
        end
    endtask

    task automatic test_alias();
        bp.if_pc = 32'h100;
        resolve(32'h100, 1'b1, 32'h80);
        resolve(32'h200, 1'b0, 32'h40);
        total++;
        if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h80) begin
            bad++;
            $display("FAIL alias_not_taken_keeps: got %0b/%h want 1/00000080",
                     bp.pred_taken, bp.pred_target);
        end
        resolve(32'h200, 1'b1, 32'h40);
        total++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h104) begin
            bad++;
            $display("FAIL alias_replaced: got %0b/%h want 0/00000104", bp.pred_taken,
                     bp.pred_target);
        end
        bp.if_pc = 32'h200;
        #1;
        total++;
        if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h40) begin
            bad++;
            $display("FAIL alias_new_entry: got %0b/%h want 1/00000040", bp.pred_taken,
                     bp.pred_target);
        end
    endtask

    task automatic test_target_change();
        bp.if_pc = 32'h100;
        resolve(32'h100, 1'b1, 32'h80);
        drive_ex(32'h100, 1'b1, 32'h80, 1'b1, 32'h90);
        total++;
        if (bp.mispredict !== 1'b1 || bp.redirect_pc !== 32'h90) begin
            bad++;
            $display("FAIL target_change_redirect: got %0b/%h want 1/00000090",
                     bp.mispredict, bp.redirect_pc);
        end
        commit_ex();
        total++;
        if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h90) begin
            bad++;
            $display("FAIL target_change_entry: got %0b/%h want 1/00000090",
                     bp.pred_taken, bp.pred_target);
        end
        drive_ex(32'h100, 1'b1, 32'h90, 1'b1, 32'h90);
        total++;
        if (bp.mispredict !== 1'b0) begin
            bad++;
            $display("FAIL target_correct: got %0b want 0", bp.mispredict);
        end
        commit_ex();
        drive_ex(32'h100, 1'b1, 32'h90, 1'b0, 32'h90);
        total++;
        if (bp.mispredict !== 1'b1 || bp.redirect_pc !== 32'h104) begin
            bad++;
            $display("FAIL taken_pred_not_taken: got %0b/%h want 1/00000104",
                     bp.mispredict, bp.redirect_pc);
        end
        commit_ex();
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tags [4] = '{32'h0, 32'h1, 32'h2, 32'h3FFFFFF};
        int          idxs [5] = '{0, 1, 2, 3, 63};
        return (tags[$urandom_range(0, 3)] << (IB + 2)) |
               (32'(idxs[$urandom_range(0, 4)]) << 2) | 32'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        logic [31:0] ipc, epc, tgt, ptgt, exp_tgt;
        bit          pt, t, ev, exp_mp;
        for (int i = 0; i < 400; i++) begin
            ipc = rand_pc();
            epc = ($urandom_range(0, 3) == 0) ? ipc : rand_pc();
            ev  = $urandom_range(0, 3) != 0;
            t   = 1'($urandom_range(0, 1));
            tgt = rand_pc() & ~32'h3;
            if ($urandom_range(0, 9) < 7) begin
                pt   = m_pred_taken(epc);
                ptgt = m_pred_target(epc);
            end else begin
                pt   = 1'($urandom_range(0, 1));
                ptgt = rand_pc() & ~32'h3;
            end
            bp.if_pc = ipc;
            drive_ex(epc, pt, ptgt, t, tgt);
            bp.ex_valid = ev;
            #1;
            exp_tgt = m_pred_target(ipc);
            total++;
            if (bp.pred_taken !== m_pred_taken(ipc) || bp.pred_target !== exp_tgt) begin
                bad++;
                $display("FAIL rand_pred[%0d] pc=%h: got %0b/%h want %0b/%h", i, ipc,
                         bp.pred_taken, bp.pred_target, m_pred_taken(ipc), exp_tgt);
            end
            exp_mp = ev && m_misp(pt, ptgt, t, tgt);
            total++;
            if (bp.mispredict !== exp_mp) begin
                bad++;
                $display("FAIL rand_mispredict[%0d]: got %0b want %0b", i, bp.mispredict,
                         exp_mp);
            end
            if (exp_mp) begin
                total++;
                if (bp.redirect_pc !== (t ? tgt : epc + 32'd4)) begin
                    bad++;
                    $display("FAIL rand_redirect[%0d]: got %h want %h", i, bp.redirect_pc,
                             t ? tgt : epc + 32'd4);
                end
            end
            commit_ex();
        end
        total++;
        if (bp.stat_branches !== (STATS ? m_br : 32'd0) ||
            bp.stat_mispredicts !== (STATS ? m_mp : 32'd0)) begin
            bad++;
            $display("FAIL rand_stats: got %0d/%0d want %0d/%0d", bp.stat_branches,
                     bp.stat_mispredicts, STATS ? m_br : 32'd0, STATS ? m_mp : 32'd0);
        end
    endtask

    task automatic test_reset_mid();
        bp.if_pc = 32'h100;
        resolve(32'h100, 1'b1, 32'h80);
        resolve(32'h100, 1'b1, 32'h80);
        rst = 1'b0;
        drive_ex(32'h300, 1'b0, 32'h304, 1'b1, 32'h20);
        total++;
        if (bp.mispredict !== 1'b0 || bp.pred_taken !== 1'b0 ||
            bp.pred_target !== 32'h104) begin
            bad++;
            $display("FAIL reset_mid_outputs: got %0b/%0b/%h want 0/0/00000104",
                     bp.mispredict, bp.pred_taken, bp.pred_target);
        end
        commit_ex();
        rst = 1'b1;
        m_reset();
        #1;
        total++;
        if (bp.pred_taken !== 1'b0 || bp.stat_branches !== 32'd0 ||
            bp.stat_mispredicts !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_cleared: got %0b/%0d/%0d want 0/0/0", bp.pred_taken,
                     bp.stat_branches, bp.stat_mispredicts);
        end
        bp.if_pc = 32'h300;
        #1;
        total++;
        if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h304) begin
            bad++;
            $display("FAIL reset_mid_discard: got %0b/%h want 0/00000304", bp.pred_taken,
                     bp.pred_target);
        end
        resolve(32'h100, 1'b0, 32'h80);
        resolve(32'h100, 1'b1, 32'h80);
        resolve(32'h108, 1'b0, 32'h80);
        total++;
        if (bp.stat_branches !== (STATS ? 32'd3 : 32'd0) ||
            bp.stat_mispredicts !== (STATS ? 32'd1 : 32'd0)) begin
            bad++;
            $display("FAIL stats_3_1: got %0d/%0d want %0d/%0d", bp.stat_branches,
                     bp.stat_mispredicts, STATS ? 3 : 0, STATS ? 1 : 0);
        end
    endtask

    initial begin
        bp.if_pc          = 32'h0;
        bp.ex_valid       = 1'b0;
        bp.ex_pc          = 32'h0;
        bp.ex_pred_taken  = 1'b0;
        bp.ex_pred_target = 32'h0;
        bp.ex_taken       = 1'b0;
        bp.ex_target      = 32'h0;
        rst               = 1'b0;
        m_reset();
        tick();
        test_reset();
        test_cold_taken();
        test_saturation();
        test_alias();
        test_target_change();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
